// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NCH-channel valid/ready multiplexer with a registered output
// stage. A channel is chosen either by the fixed index `s` or by round-robin
// arbitration over all valid channels. The chosen word is captured into a
// single output register that drains with `o_ready`.

module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      s,
    input  logic [NCH*WIDTH-1:0] i,
    input  logic [NCH-1:0]       i_valid,
    output logic [NCH-1:0]       i_ready,
    output logic [WIDTH-1:0]     o,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [SELW-1:0]      o_ch
);

    // Channel granted in the previous round-robin transfer; the next
    // round-robin search starts one position after it.
    logic [SELW-1:0]  last;

    // Output register can take a word: it is empty or drains this cycle.
    logic             load;

    // Candidate grants from each selection mode.
    logic             fix_valid;
    logic [SELW-1:0]  fix_idx;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    int               rr_dist;

    // Grant actually used this cycle, and the data word it selects.
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

    // Load enable: a new word may enter when the register is free or draining.
    always_comb begin
        load = !o_valid || o_ready;
    end

    // Fixed-select grant: channel `s` when it exists and is valid. An index
    // at or above NCH matches no channel, so it never grants.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        fix_valid = 1'b0;
        fix_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s == SELW'(k) && i_valid[k]) begin
                fix_valid = 1'b1;
                fix_idx   = SELW'(k);
            end
        end
    end

    // Round-robin grant: among the valid channels, pick the one closest
    // after `last` in wrap-around order. The distance of channel k from the
    // search start (last+1) is (k - last - 1) mod NCH; the smallest wins.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        rr_dist  = NCH;
        for (int k = 0; k < NCH; k++) begin
            if (i_valid[k] && ((k + NCH - 1 - int'(last)) % NCH) < rr_dist) begin
                rr_valid = 1'b1;
                rr_idx   = SELW'(k);
                rr_dist  = (k + NCH - 1 - int'(last)) % NCH;
            end
        end
    end

    // Mode select between the two grant sources; mode and `s` only affect
    // the decision made this cycle, never a word already held in `o`.
    always_comb begin
        grant_valid = mode ? rr_valid : fix_valid;
        grant       = mode ? rr_idx   : fix_idx;
    end

    // Data select for the granted channel.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready: one-hot on the granted channel while the register can load;
    // held at zero while reset is asserted.
    always_comb begin
        i_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rst_n && load && grant_valid && grant == SELW'(k)) begin
                i_ready[k] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer. A transfer loads the granted
    // word; a free slot with no grant empties; backpressure holds everything.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, and every state bit is
        // reset (the data word too) so a word held at reset is discarded
        // and the outputs read as zero afterwards.
        if (!rst_n) begin
            o       <= '0;
            o_valid <= 1'b0;
            o_ch    <= '0;
            last    <= SELW'(NCH - 1);
        end else if (load) begin
            if (grant_valid) begin
                o       <= grant_data;
                o_ch    <= grant;
                o_valid <= 1'b1;
                if (mode) begin
                    last <= grant;
                end
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenarios on a 4-channel and a 3-channel
// instance, then randomized traffic on the 4-channel instance compared
// against a behavioural model of the selection and output-register rules.

module tb_stream_mux_rr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rst_n;
    logic        mode;
    logic [1:0]  s;
    logic [31:0] din;
    logic [3:0]  i_valid;
    logic [3:0]  i_ready;
    logic [7:0]  o;
    logic        o_valid;
    logic        o_ready;
    logic [1:0]  o_ch;

    // 3-channel instance
    logic        rst3_n;
    logic        mode3;
    logic [1:0]  s3;
    logic [23:0] din3;
    logic [2:0]  i_valid3;
    logic [2:0]  i_ready3;
    logic [7:0]  o3;
    logic        o_valid3;
    logic        o_ready3;
    logic [1:0]  o_ch3;

    int total = 0;
    int bad   = 0;

    // Reference model state for the 4-channel instance
    logic [7:0]  m_o;
    logic        m_v;
    int          m_ch;
    int          m_last;

    logic [7:0]  dat [4];

    stream_mux_rr #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .i(din),
        .i_valid(i_valid), .i_ready(i_ready), .o(o), .o_valid(o_valid),
        .o_ready(o_ready), .o_ch(o_ch)
    );

    stream_mux_rr #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3), .s(s3), .i(din3),
        .i_valid(i_valid3), .i_ready(i_ready3), .o(o3), .o_valid(o_valid3),
        .o_ready(o_ready3), .o_ch(o_ch3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Grant from the selection rules: fixed index if in range and valid,
    // otherwise the first valid channel found walking forward from last+1.
    function automatic int ref_grant(input int nch, input logic md, input int sel,
                                     input logic [15:0] vld, input int lst);
        if (!md) begin
            if (sel < nch && ((vld >> sel) & 16'h1) != 16'h0) return sel;
            return -1;
        end
        for (int d = 1; d <= nch; d++) begin
            int c;
            c = (lst + d) % nch;
            if (((vld >> c) & 16'h1) != 16'h0) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_ready();
        int g;
        g = ref_grant(4, mode, int'(s), {12'b0, i_valid}, m_last);
        if (!rst_n || !(!m_v || o_ready) || g < 0) return 32'h0;
        return 32'h1 << g;
    endfunction

    // Advance one clock: model next state from the inputs present before
    // the edge, then commit it #1 after the edge.
    task automatic step();
        int         g;
        logic [7:0] n_o;
        logic       n_v;
        int         n_ch;
        int         n_last;
        g      = ref_grant(4, mode, int'(s), {12'b0, i_valid}, m_last);
        n_o    = m_o;
        n_v    = m_v;
        n_ch   = m_ch;
        n_last = m_last;
        if (!rst_n) begin
            n_o = 8'h00; n_v = 1'b0; n_ch = 0; n_last = 3;
        end else if (!m_v || o_ready) begin
            if (g >= 0) begin
                n_o  = din[g*8 +: 8];
                n_ch = g;
                n_v  = 1'b1;
                if (mode) n_last = g;
            end else begin
                n_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_o = n_o; m_v = n_v; m_ch = n_ch; m_last = n_last;
    endtask

    task automatic check_model();
        check("model_o", {24'b0, o}, {24'b0, m_o});
        check("model_o_valid", {31'b0, o_valid}, {31'b0, m_v});
        check("model_o_ch", {30'b0, o_ch}, m_ch);
    endtask

    task automatic check_ready();
        check("model_i_ready", {28'b0, i_ready}, exp_ready());
    endtask

    initial begin
        dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3; dat[3] = 8'hD4;
        m_o = 8'h00; m_v = 1'b0; m_ch = 0; m_last = 3;

        rst_n = 1'b0; mode = 1'b0; s = 2'd0; din = 32'hD4C3B2A1;
        i_valid = 4'hF; o_ready = 1'b1;
        rst3_n = 1'b0; mode3 = 1'b0; s3 = 2'd3; din3 = 24'hC3B2A1;
        i_valid3 = 3'b111; o_ready3 = 1'b1;

        // Reset held for three cycles with traffic present
        repeat (3) begin
            step();
            check("rst_o", {24'b0, o}, 32'h00);
            check("rst_o_valid", {31'b0, o_valid}, 32'h0);
            check("rst_o_ch", {30'b0, o_ch}, 32'h0);
            check("rst_i_ready", {28'b0, i_ready}, 32'h0);
            check("rst3_i_ready", {29'b0, i_ready3}, 32'h0);
        end

        // Fixed mode, s=1
        rst_n = 1'b1; rst3_n = 1'b1; s = 2'd1;
        #1;
        check("fix_ready", {28'b0, i_ready}, 32'b0010);
        repeat (3) begin
            step();
            check("fix_o", {24'b0, o}, 32'hB2);
            check("fix_o_ch", {30'b0, o_ch}, 32'd1);
            check("fix_o_valid", {31'b0, o_valid}, 32'd1);
            check("fix_ready_hold", {28'b0, i_ready}, 32'b0010);
            check_model();
        end
        s = 2'd3;
        #1;
        check("fix3_ready", {28'b0, i_ready}, 32'b1000);
        step();
        check("fix3_o", {24'b0, o}, 32'hD4);
        check("fix3_o_ch", {30'b0, o_ch}, 32'd3);
        check_model();

        // Round-robin, all valid: first priority is channel 0
        mode = 1'b1;
        #1;
        for (int n = 0; n < 6; n++) begin
            check("rr_ready", {28'b0, i_ready}, 32'h1 << (n % 4));
            step();
            check("rr_o_ch", {30'b0, o_ch}, n % 4);
            check("rr_o", {24'b0, o}, {24'b0, dat[n % 4]});
            check_model();
        end

        // Backpressure after channel 1 loaded
        o_ready = 1'b0;
        #1;
        repeat (3) begin
            check("bp_ready", {28'b0, i_ready}, 32'h0);
            step();
            check("bp_o", {24'b0, o}, 32'hB2);
            check("bp_o_valid", {31'b0, o_valid}, 32'd1);
            check("bp_o_ch", {30'b0, o_ch}, 32'd1);
        end
        o_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'b0, i_ready}, 32'b0100);
        step();
        check("bp_release_o_ch", {30'b0, o_ch}, 32'd2);
        check("bp_release_o", {24'b0, o}, 32'hC3);

        // Sparse round-robin: reach a grant to channel 0, then 4'b1001
        step();
        check("sp_pre_ch3", {30'b0, o_ch}, 32'd3);
        step();
        check("sp_pre_ch0", {30'b0, o_ch}, 32'd0);
        i_valid = 4'b1001;
        #1;
        check("sp_ready", {28'b0, i_ready}, 32'b1000);
        for (int n = 0; n < 3; n++) begin
            step();
            check("sp_o_ch", {30'b0, o_ch}, (n % 2 == 0) ? 32'd3 : 32'd0);
            check_model();
        end
        i_valid = 4'b0000;
        #1;
        check("sp_idle_ready", {28'b0, i_ready}, 32'h0);
        step();
        check("sp_idle_o_valid", {31'b0, o_valid}, 32'd0);
        check("sp_idle_o_hold", {24'b0, o}, 32'hD4);
        check("sp_idle_o_ch_hold", {30'b0, o_ch}, 32'd3);

        // Three channels: out-of-range select never grants
        check("oor_ready", {29'b0, i_ready3}, 32'h0);
        check("oor_o_valid", {31'b0, o_valid3}, 32'h0);
        step();
        check("oor_ready2", {29'b0, i_ready3}, 32'h0);
        check("oor_o_valid2", {31'b0, o_valid3}, 32'h0);
        s3 = 2'd2;
        #1;
        check("n3_ready", {29'b0, i_ready3}, 32'b100);
        step();
        check("n3_o_valid", {31'b0, o_valid3}, 32'd1);
        check("n3_o", {24'b0, o3}, 32'hC3);
        check("n3_o_ch", {30'b0, o_ch3}, 32'd2);

        // Reset mid-operation discards the held word
        rst3_n = 1'b0;
        #1;
        check("midrst_ready", {29'b0, i_ready3}, 32'h0);
        step();
        check("midrst_o_valid", {31'b0, o_valid3}, 32'd0);
        check("midrst_o", {24'b0, o3}, 32'h00);
        check("midrst_o_ch", {30'b0, o_ch3}, 32'd0);
        rst3_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 49) != 0);
            mode    = 1'($urandom_range(0, 1));
            s       = 2'($urandom_range(0, 3));
            din     = $urandom;
            i_valid = 4'($urandom_range(0, 15));
            o_ready = ($urandom_range(0, 3) != 0);
            #1;
            check_ready();
            step();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer that selects one of `NCH` valid/ready input channels and holds it in a registered output stage. It replaces the combinational 4:1 select with a flow-controlled block. The block has two selection modes: fixed-select, where the channel comes from `s`, and round-robin arbitration across all valid channels. It sits between multiple producers and a single downstream consumer.

## Interface
- `WIDTH`, default 8: data bits per channel.
- `NCH`, default 4: number of input channels, legal range 2..16. `SELW = $clog2(NCH)` is derived locally.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  1  0 = fixed select via `s`, 1 = round-robin.
- `s`  in  SELW  fixed-mode channel index.
- `i`  in  NCH*WIDTH  packed channel data; channel k occupies `i[k*WIDTH +: WIDTH]`.
- `i_valid`  in  NCH  per-channel valid.
- `i_ready`  out  NCH  per-channel ready. At most one bit is set in any cycle.
- `o`  out  WIDTH  registered output data.
- `o_valid`  out  1  output register holds a word.
- `o_ready`  in  1  consumer accepts `o` this cycle.
- `o_ch`  out  SELW  channel index the word in `o` came from.

## Operation
- **Load enable:** `load = !o_valid || o_ready`. The output register accepts a new word only when it is empty or being drained in the same cycle.
- **Grant in fixed mode:**
  - The grant goes to channel `s` when `i_valid[s]=1` and `s < NCH`.
  - Otherwise there is no grant.
- **Grant in round-robin mode:**
  - The search starts at `(last+1) mod NCH` and wraps around.
  - The first channel found with `i_valid=1` is granted.
  - If no channel is valid, there is no grant.
- **Ready:** `i_ready[k] = load && grant==k`. There is a combinational path from `o_ready`, `i_valid`, `mode` and `s` to `i_ready`.
- **Transfer on channel k (`i_valid[k] && i_ready[k]`):**
  - `o` takes channel k data, `o_ch` takes k, and `o_valid` is set to 1.
  - In mode 1, `last` is updated to k.
- **No grant while `load` is high:**
  - If `o_ready=1`, `o_valid` clears to 0.
  - `o` and `o_ch` hold their values.
- **Backpressure (`o_valid && !o_ready`):**
  - `o` and `o_ch` hold stable.
  - All `i_ready` bits are 0.
- **Pointer handling:**
  - `last` is updated only by mode-1 transfers.
  - It is retained unchanged through mode-0 periods.
- **Mode or `s` change:** takes effect at the next grant decision. It never alters a word already held in `o`.
- **Simultaneous drain and load:** the new word replaces the drained one in the same edge, so there is no bubble.

## Timing
- **Reset values** while `rst_n=0` is sampled low at an edge:
  - `o=0`, `o_valid=0`, `o_ch=0`.
  - `last=NCH-1`, so channel 0 has first priority after reset.
  - `i_ready` is forced to all zeros while `rst_n=0`.
- **Reset mid-operation:** the held word is discarded without handshake.
- **Latency:** 1 cycle from input transfer to `o_valid`/`o` visible.
- **Throughput:** 1 word/cycle sustained while `o_ready=1` and a grantable channel is valid.
- **Round-robin fairness:** with all channels continuously valid, each channel is served once every NCH transfers.

## Test plan
1. **Reset:**
   - Stimulus: `rst_n=0` for 3 cycles with `i_valid=4'b1111` and `o_ready=1`.
   - Response: every cycle shows `o=8'h00`, `o_valid=0`, `o_ch=0`, `i_ready=4'b0000`.
2. **Fixed mode:**
   - Stimulus: `i={8'hD4,8'hC3,8'hB2,8'hA1}`, `mode=0`, `s=2'b01`, all valid, `o_ready=1`.
   - Response: `i_ready=4'b0010`; one cycle after the first transfer `o=8'hB2` and `o_ch=1`, holding every cycle.
   - Then switch to `s=2'b11`: the next word is `8'hD4` with `o_ch=3`.
3. **Round-robin, all valid:**
   - Stimulus: same data, `mode=1`, `o_ready=1`.
   - Response: `o_ch` sequence 0,1,2,3,0,1 on consecutive cycles, with `o` = A1,B2,C3,D4,A1,B2.
4. **Backpressure:**
   - Stimulus: in round-robin, hold `o_ready=0` for 3 cycles after `o_ch=1` loads.
   - Response: `o=8'hB2` and `o_valid=1` stay stable, `i_ready=4'b0000`.
   - After release, the next word is `o_ch=2`, `o=8'hC3`.
5. **Sparse round-robin:**
   - Stimulus: after a grant to channel 0, set `i_valid=4'b1001`.
   - Response: next grants are channel 3, then 0, then 3.
   - Then drop to `i_valid=4'b0000` with `o_ready=1`: `o_valid` clears after one cycle.
6. **Out-of-range select and reset mid-operation:**
   - Stimulus: with `NCH=3`, `mode=0`, `s=2'b11`, all valid.
   - Response: `i_ready=3'b000` and `o_valid` stays 0.
   - Then assert `rst_n=0` for one cycle while `o_valid=1`: `o_valid=0` and `o=0` on the following cycle.
